// File: rtl/conv_window_gen.sv
// conv_window_gen
// Builds 3x3 pixel windows from a raster-order pixel stream for the
// downstream 3x3 convolution stage. Two line buffers hold the previous two
// image rows. Three 3-pixel shift registers present the window as packed
// row words.
//
// Parameters:
//   DW    - bits per pixel
//   IMG_W - image width in pixels (>=3)
//   IMG_H - image height in rows (>=3)
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - synchronous, active-low reset
//   in_valid   - pixel beat valid (no backpressure)
//   in_sof     - start of frame, qualified by in_valid; pixel is (0,0)
//   in_pixel   - pixel value
//   data_im_a  - window row r-2, {col c-2, col c-1, col c}
//   data_im_b  - window row r-1, same packing
//   data_im_c  - window row r,   same packing
//   win_valid  - data_im_a/b/c hold a complete window this cycle
//   frame_done - pulse coincident with the last window of a frame
//   conv_valid - win_valid delayed by 2 cycles when CONV_VALID_ALIGN_EN is
//                defined, otherwise constant 0
//
// Build option: CONV_VALID_ALIGN_EN enables the 2-cycle conv_valid delay line.
module conv_window_gen #(
   parameter int DW    = 8,
   parameter int IMG_W = 28,
   parameter int IMG_H = 28
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   input  logic            in_sof,
   input  logic [DW-1:0]   in_pixel,
   output logic [3*DW-1:0] data_im_a,
   output logic [3*DW-1:0] data_im_b,
   output logic [3*DW-1:0] data_im_c,
   output logic            win_valid,
   output logic            frame_done,
   output logic            conv_valid
);

   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

   logic [CW-1:0]   col_q, col_d;
   logic [RW-1:0]   row_q, row_d;
   logic [3*DW-1:0] a_q, a_d;
   logic [3*DW-1:0] b_q, b_d;
   logic [3*DW-1:0] c_q, c_d;
   logic            win_valid_q, win_valid_d;
   logic            frame_done_q, frame_done_d;

   // Line buffers. They are not reset: every entry is rewritten before
   // it can reach a valid window.
   logic [DW-1:0]   lb1_q [IMG_W];
   logic [DW-1:0]   lb2_q [IMG_W];

   logic [CW-1:0]   col_eff_s;
   logic [RW-1:0]   row_eff_s;
   logic [DW-1:0]   t1_s;
   logic [DW-1:0]   t2_s;
   logic            last_col_s;
   logic            last_row_s;

   // Position of the pixel on the input this cycle, plus the line buffer read.
   always_comb begin
      if (in_sof) begin
         col_eff_s = {CW{1'b0}};
         row_eff_s = {RW{1'b0}};
      end else begin
         col_eff_s = col_q;
         row_eff_s = row_q;
      end
      t1_s       = lb1_q[col_eff_s];
      t2_s       = lb2_q[col_eff_s];
      last_col_s = (col_eff_s == CW'(IMG_W - 1));
      last_row_s = (row_eff_s == RW'(IMG_H - 1));
   end

   // Next-state logic for the counters, shift registers and flags.
   always_comb begin
      col_d        = col_q;
      row_d        = row_q;
      a_d          = a_q;
      b_d          = b_q;
      c_d          = c_q;
      win_valid_d  = 1'b0;
      frame_done_d = 1'b0;
      if (in_valid) begin
         // Each row word shifts left so the newest pixel lands in the LSBs.
         c_d = {c_q[2*DW-1:0], in_pixel};
         b_d = {b_q[2*DW-1:0], t1_s};
         a_d = {a_q[2*DW-1:0], t2_s};
         win_valid_d  = (row_eff_s >= RW'(2)) && (col_eff_s >= CW'(2));
         frame_done_d = last_row_s && last_col_s;
         if (last_col_s) begin
            col_d = {CW{1'b0}};
            if (last_row_s) begin
               row_d = {RW{1'b0}};
            end else begin
               row_d = row_eff_s + RW'(1);
            end
         end else begin
            col_d = col_eff_s + CW'(1);
            row_d = row_eff_s;
         end
      end else begin
         win_valid_d  = 1'b0;
         frame_done_d = 1'b0;
      end
   end

   // Line buffer update: row r-1 moves down to r-2 and the new pixel becomes row r-1.
   always_ff @(posedge clk) begin
      if (in_valid) begin
         lb2_q[col_eff_s] <= t1_s;
         lb1_q[col_eff_s] <= in_pixel;
      end
   end

   // Counter, window and flag registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         col_q        <= {CW{1'b0}};
         row_q        <= {RW{1'b0}};
         a_q          <= {(3*DW){1'b0}};
         b_q          <= {(3*DW){1'b0}};
         c_q          <= {(3*DW){1'b0}};
         win_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         a_q          <= a_d;
         b_q          <= b_d;
         c_q          <= c_d;
         win_valid_q  <= win_valid_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign data_im_a  = a_q;
   assign data_im_b  = b_q;
   assign data_im_c  = c_q;
   assign win_valid  = win_valid_q;
   assign frame_done = frame_done_q;

`ifdef CONV_VALID_ALIGN_EN
   logic [1:0] dly_q;

   // Free-running 2-stage delay of win_valid, aligned with the conv stage output.
   always_ff @(posedge clk) begin
      if (!reset) begin
         dly_q <= 2'b00;
      end else begin
         dly_q <= {dly_q[0], win_valid_q};
      end
   end

   assign conv_valid = dly_q[1];
`else
   assign conv_valid = 1'b0;
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
module tb_conv_window_gen;

   localparam int DW = 8;
   localparam int W  = 5;
   localparam int H  = 4;

   logic          clk;
   logic          reset;
   logic          in_valid;
   logic          in_sof;
   logic [DW-1:0] in_pixel;
   logic [23:0]   data_im_a, data_im_b, data_im_c;
   logic          win_valid, frame_done, conv_valid;

   int total_cnt = 0;
   int bad_cnt   = 0;
   int win_cnt   = 0;

   // Reference model state: frame image, stream position, expected outputs.
   int          img [H][W];
   int          pos_r, pos_c;
   logic [23:0] ea, eb, ec;
   logic        dchk;
   logic        ewv, efd, ecv, h1;

   conv_window_gen #(.DW(DW), .IMG_W(W), .IMG_H(H)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_sof(in_sof),
      .in_pixel(in_pixel), .data_im_a(data_im_a), .data_im_b(data_im_b),
      .data_im_c(data_im_c), .win_valid(win_valid), .frame_done(frame_done),
      .conv_valid(conv_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total_cnt++;
      if (got !== exp) begin
         bad_cnt++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [23:0] row_word(input int r, input int c);
      logic [23:0] w;
      w = {img[r][c-2][7:0], img[r][c-1][7:0], img[r][c][7:0]};
      return w;
   endfunction

   // One clock cycle: drive, advance the model at the edge, check just after it.
   task automatic step(input logic v, input logic s, input logic [7:0] p, input logic rst);
      int r, c;
      reset    = ~rst;
      in_valid = v;
      in_sof   = s;
      in_pixel = p;
      @(posedge clk);
      if (rst) begin
         pos_r = 0; pos_c = 0;
         ea = '0; eb = '0; ec = '0;
         dchk = 1'b1;
         ewv = 1'b0; efd = 1'b0; h1 = 1'b0; ecv = 1'b0;
      end else begin
`ifdef CONV_VALID_ALIGN_EN
         ecv = h1;
`else
         ecv = 1'b0;
`endif
         h1 = ewv;
         if (v) begin
            r = s ? 0 : pos_r;
            c = s ? 0 : pos_c;
            img[r][c] = p;
            ewv = (r >= 2) && (c >= 2);
            efd = (r == H-1) && (c == W-1);
            if (ewv) begin
               ea = row_word(r-2, c);
               eb = row_word(r-1, c);
               ec = row_word(r, c);
               dchk = 1'b1;
            end else begin
               dchk = 1'b0;
            end
            c++;
            if (c == W) begin
               c = 0;
               r = (r + 1) % H;
            end
            pos_r = r; pos_c = c;
         end else begin
            ewv = 1'b0;
            efd = 1'b0;
         end
      end
      #1;
      check_val("win_valid", win_valid, ewv);
      check_val("frame_done", frame_done, efd);
      check_val("conv_valid", conv_valid, ecv);
      if (dchk) begin
         check_val("data_a", data_im_a, ea);
         check_val("data_b", data_im_b, eb);
         check_val("data_c", data_im_c, ec);
      end
      if (win_valid) win_cnt++;
   endtask

   task automatic px(input int r, input int c, input int base);
      logic [7:0] v;
      v = 8'(base + r*16 + c);
      step(1'b1, (r == 0) && (c == 0), v, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic plain_frame(input int base);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            px(r, c, base);
   endtask

   initial begin
      reset = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_pixel = '0;
      pos_r = 0; pos_c = 0; dchk = 1'b0;
      ea = '0; eb = '0; ec = '0; ewv = 1'b0; efd = 1'b0; ecv = 1'b0; h1 = 1'b0;
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            img[r][c] = 0;

      // Reset state
      step(1'b0, 1'b0, 8'h00, 1'b1);
      step(1'b1, 1'b1, 8'h55, 1'b1);
      idle(2);

      // Continuous frame
      win_cnt = 0;
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) begin
            px(r, c, 0);
            if (r == 2 && c == 2) begin
               check_val("s1_first_a", data_im_a, 24'h000102);
               check_val("s1_first_b", data_im_b, 24'h101112);
               check_val("s1_first_c", data_im_c, 24'h202122);
            end
            if (r == H-1 && c == W-1) begin
               check_val("s1_last_fd", frame_done, 1'b1);
               check_val("s1_last_a", data_im_a, 24'h121314);
               check_val("s1_last_b", data_im_b, 24'h222324);
               check_val("s1_last_c", data_im_c, 24'h323334);
            end
         end
      idle(3);
      check_val("s1_windows", win_cnt, 6);

      // Gap of 3 idle cycles after (2,3)
      win_cnt = 0;
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) begin
            px(r, c, 0);
            if (r == 2 && c == 3) idle(3);
            if (r == 2 && c == 4) begin
               check_val("s2_resume_a", data_im_a, 24'h020304);
               check_val("s2_resume_b", data_im_b, 24'h121314);
               check_val("s2_resume_c", data_im_c, 24'h222324);
            end
         end
      idle(2);
      check_val("s2_windows", win_cnt, 6);

      // Back-to-back frames
      plain_frame(0);
      win_cnt = 0;
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) begin
            px(r, c, 8'h80);
            if (r == 2 && c == 2) begin
               check_val("s3_first_a", data_im_a, 24'h808182);
               check_val("s3_first_b", data_im_b, 24'h909192);
               check_val("s3_first_c", data_im_c, 24'hA0A1A2);
            end
         end
      idle(2);
      check_val("s3_windows", win_cnt, 6);

      // Reset after (2,3), then a new frame
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < W; c++)
            if (r < 2 || c <= 3) px(r, c, 8'h40);
      step(1'b0, 1'b0, 8'h00, 1'b1);
      check_val("s4_rst_a", data_im_a, 24'h0);
      check_val("s4_rst_wv", win_valid, 1'b0);
      win_cnt = 0;
      plain_frame(8'h10);
      idle(2);
      check_val("s4_windows", win_cnt, 6);

      // in_sof restart at position (1,2)
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < W; c++)
            if (r == 0 || c < 2) px(r, c, 8'h60);
      win_cnt = 0;
      plain_frame(8'h20);
      idle(2);
      check_val("s5_windows", win_cnt, 6);

      // Random pixels with random idle gaps
      for (int f = 0; f < 4; f++) begin
         win_cnt = 0;
         for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
               step(1'b1, (r == 0) && (c == 0), 8'($urandom), 1'b0);
               if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
            end
         idle(2);
         check_val("rnd_windows", win_cnt, 6);
      end

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
